// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and helpers for the configuration-chain loader.
//   state_t : loader FSM states (IDLE, LOAD, SHIFT, FLUSH, DONE)
//   nwords  : number of bitstream words needed to fill a chain
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // ceil(chain_len / word_w)
    function automatic int nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 32'sd1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// ---------------------------------------------------------------------------
// ccff_word_serdes
// Paired load/shift register and readback packer for one bitstream word.
//   clk, rst     : clock and synchronous active-high reset
//   load         : capture load_data / load_nbits (word handshake)
//   load_data    : bitstream word, MSB leaves first
//   load_nbits   : number of valid bits in this word (1..WORD_W)
//   shift        : one chain advance this edge
//   tail         : bit currently at the chain tail (captured on shift)
//   head         : bit presented to the chain head
//   last_bit     : the current bit is the final one of this word
//   packed_word  : readback word as it will look after this edge,
//                  left-justified and zero-padded for a partial word
// ---------------------------------------------------------------------------
module ccff_word_serdes
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BIT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BIT_W-1:0]  load_nbits,
    input  logic              shift,
    input  logic              tail,
    output logic              head,
    output logic              last_bit,
    output logic [WORD_W-1:0] packed_word
);

    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_W);

    logic [WORD_W-1:0] shreg_r;
    logic [WORD_W-1:0] rb_shreg_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [BIT_W-1:0]  nbits_r;
    logic [WORD_W-1:0] full_s;

    assign head     = shreg_r[WORD_W-1];
    assign last_bit = (bit_cnt_r == BIT_ONE);

    // Readback word including the bit being captured on this edge; shifted up so a short word is left-justified.
    always_comb begin
        full_s      = rb_shreg_r << 1'b1;
        full_s[0]   = tail;
        packed_word = full_s << (BIT_FULL - nbits_r);
    end

    // Word capture and per-bit shifting of both the outgoing and readback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r    <= '0;
            rb_shreg_r <= '0;
            bit_cnt_r  <= '0;
            nbits_r    <= '0;
        end else if (load) begin
            shreg_r   <= load_data;
            bit_cnt_r <= load_nbits;
            nbits_r   <= load_nbits;
        end else if (shift) begin
            shreg_r    <= shreg_r << 1'b1;
            rb_shreg_r <= full_s;
            bit_cnt_r  <= bit_cnt_r - BIT_ONE;
        end else begin
            shreg_r    <= shreg_r;
            rb_shreg_r <= rb_shreg_r;
            bit_cnt_r  <= bit_cnt_r;
            nbits_r    <= nbits_r;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
// Drives the frac_logic configuration chain: serialises bitstream words
// MSB-first onto ccff_head, packs the bits leaving ccff_tail into readback
// words, and produces the shift enable used to gate prog_clk to the chain.
//   prog_clk, prog_reset  : clock, synchronous active-high reset
//   start                 : begin a load (sampled in IDLE only)
//   cfg_data/valid/ready  : bitstream word stream
//   ccff_head, ccff_tail  : serial chain data out / in
//   ccff_shift_en         : chain advances on edges where this is 1
//   rb_data/valid/ready   : readback word stream
//   busy                  : load in progress (any state but IDLE)
//   done                  : one-cycle pulse at end of load
// ---------------------------------------------------------------------------
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 21
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 32'sd1);
    localparam int BIT_W  = $clog2(WORD_W + 32'sd1);
    localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
    localparam int WCNT_W = $clog2(NWORDS + 32'sd1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1'b1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(NWORDS);

    state_t             state_r;
    logic [CNT_W-1:0]   remaining_r;
    logic [WCNT_W-1:0]  words_r;
    logic               cfg_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               rb_valid_r;
    logic [WORD_W-1:0]  rb_data_r;

    logic               cfg_hs_s;
    logic               shift_en_s;
    logic [BIT_W-1:0]   nbits_s;
    logic               last_bit_s;
    logic               head_s;
    logic [WORD_W-1:0]  packed_s;

    assign cfg_ready     = cfg_ready_r;
    assign ccff_head     = head_s;
    assign ccff_shift_en = shift_en_s;
    assign rb_data       = rb_data_r;
    assign rb_valid      = rb_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Bits to shift for the next word: a full word, or whatever is left of the chain.
    always_comb begin
        nbits_s = '0;
        if (32'(remaining_r) >= WORD_W) begin
            nbits_s = BIT_W'(WORD_W);
        end else begin
            nbits_s = BIT_W'(remaining_r);
        end
    end

    // Word handshake; the word count guard keeps surplus words from ever being taken.
    always_comb begin
        cfg_hs_s = 1'b0;
        if ((state_r == LOAD) && cfg_ready_r && cfg_valid && (words_r < WCNT_MAX)) begin
            cfg_hs_s = 1'b1;
        end else begin
            cfg_hs_s = 1'b0;
        end
    end

    // Chain clock enable: stall on a word's last bit while the previous readback is unconsumed,
    // and drop immediately when reset is asserted so an abort issues no extra edge.
    always_comb begin
        shift_en_s = 1'b0;
        if ((state_r == SHIFT) && !prog_reset) begin
            if (last_bit_s && rb_valid_r && !rb_ready) begin
                shift_en_s = 1'b0;
            end else begin
                shift_en_s = 1'b1;
            end
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            words_r     <= '0;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rb_valid_r  <= 1'b0;
            rb_data_r   <= '0;
        end else begin
            done_r <= 1'b0;
            // Consumed readback clears here; a new word set later in this block wins.
            if (rb_valid_r && rb_ready) begin
                rb_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= LOAD;
                        remaining_r <= CNT_FULL;
                        words_r     <= '0;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_hs_s) begin
                        state_r     <= SHIFT;
                        cfg_ready_r <= 1'b0;
                        words_r     <= words_r + WCNT_ONE;
                    end
                end
                SHIFT: begin
                    if (shift_en_s) begin
                        remaining_r <= remaining_r - CNT_ONE;
                        if (last_bit_s) begin
                            rb_data_r  <= packed_s;
                            rb_valid_r <= 1'b1;
                            if (remaining_r == CNT_ONE) begin
                                state_r <= FLUSH;
                            end else begin
                                state_r     <= LOAD;
                                cfg_ready_r <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (rb_valid_r && rb_ready) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cfg_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    ccff_word_serdes #(
        .WORD_W (WORD_W),
        .BIT_W  (BIT_W)
    ) u_serdes (
        .clk         (prog_clk),
        .rst         (prog_reset),
        .load        (cfg_hs_s),
        .load_data   (cfg_data),
        .load_nbits  (nbits_s),
        .shift       (shift_en_s),
        .tail        (ccff_tail),
        .head        (head_s),
        .last_bit    (last_bit_s),
        .packed_word (packed_s)
    );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
// Directed bench for ccff_bitstream_loader with a 21-bit chain model that
// advances on edges where ccff_shift_en is 1.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 21;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              rb_ready;
    logic              busy;
    logic              done;

    logic [CHAIN_LEN-1:0] chain = '0;
    int shift_cnt = 0;
    int hs_cnt    = 0;
    int rb_n      = 0;
    logic [7:0] rb_words [0:63];
    int tests = 0;
    int fails = 0;

    ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .rb_ready      (rb_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = chain[CHAIN_LEN-1];

    // Chain model plus counters of shifts, accepted words and consumed readback words.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain     <= {chain[CHAIN_LEN-2:0], ccff_head};
            shift_cnt <= shift_cnt + 1;
        end
        if (cfg_valid && cfg_ready) hs_cnt <= hs_cnt + 1;
        if (rb_valid && rb_ready) begin
            rb_words[rb_n[5:0]] <= rb_data;
            rb_n <= rb_n + 1;
        end
    end

    // Runs one load; start is sampled at the end of cycle t, done_cyc is the offset of the done cycle.
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int gap, input int rb_stall, input bit keep_valid,
                            input int start_pulse, input logic [7:0] stall_exp,
                            output int done_cyc, output int gap_bad,
                            output int stall_seen, output int stall_bad);
        logic [7:0] words [0:2];
        int hb, rel, gap_left, cyc;
        bit gap_now;
        words[0] = w0; words[1] = w1; words[2] = w2;
        hb = hs_cnt; gap_left = gap; done_cyc = -1;
        gap_bad = 0; stall_seen = 0; stall_bad = 0;
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = keep_valid; cfg_data = w0; rb_ready = (rb_stall == 0);
        @(posedge prog_clk);
        cyc = 1;
        while (cyc < 200) begin
            @(negedge prog_clk);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start    = (cyc == start_pulse);
            rel      = hs_cnt - hb;
            gap_now  = (rel == 1) && (cfg_ready === 1'b1) && (gap_left > 0);
            if (gap_now) gap_left--;
            cfg_data  = (rel < 3) ? words[rel[1:0]] : 8'hEE;
            cfg_valid = keep_valid || ((rel < 3) && !gap_now);
            rb_ready  = (stall_seen >= rb_stall);
            #1;
            if (gap_now && ccff_shift_en) gap_bad++;
            if (!rb_ready && rb_valid && busy && !cfg_ready && !ccff_shift_en) begin
                stall_seen++;
                if (rb_data !== stall_exp) stall_bad++;
            end
            @(posedge prog_clk);
            cyc++;
        end
        start = 1'b0; rb_ready = 1'b1; cfg_valid = keep_valid;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; rb_ready = 1'b1;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        tests++;
        if ({cfg_ready, ccff_shift_en, rb_valid, busy, done, ccff_head} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000", {cfg_ready, ccff_shift_en, rb_valid, busy, done, ccff_head});
            fails++;
        end
        tests++;
        if (rb_data !== 8'h00) begin
            $display("FAIL reset_rb_data: got %h expected 00", rb_data);
            fails++;
        end
        prog_reset = 1'b0;
        repeat (2) @(negedge prog_clk);
        tests++;
        if ({busy, cfg_ready, ccff_shift_en} !== 3'b000) begin
            $display("FAIL reset_idle_hold: got %b expected 000", {busy, cfg_ready, ccff_shift_en});
            fails++;
        end
    endtask

    task automatic test_basic();
        int sb, hb, rbb, dc, gb, ss, sbad;
        sb = shift_cnt; hb = hs_cnt; rbb = rb_n;
        run_load(8'hA5, 8'h3C, 8'hF8, 0, 0, 1'b0, 0, 8'h00, dc, gb, ss, sbad);
        tests++; if (dc !== 26) begin $display("FAIL basic_done_cycle: got %0d expected 26", dc); fails++; end
        tests++; if (shift_cnt - sb !== 21) begin $display("FAIL basic_shifts: got %0d expected 21", shift_cnt - sb); fails++; end
        tests++; if (hs_cnt - hb !== 3) begin $display("FAIL basic_words: got %0d expected 3", hs_cnt - hb); fails++; end
        tests++; if (rb_n - rbb !== 3) begin $display("FAIL basic_rb_count: got %0d expected 3", rb_n - rbb); fails++; end
        tests++;
        if ({rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]} !== 24'h000000) begin
            $display("FAIL basic_rb_words: got %h %h %h expected 00 00 00",
                     rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]);
            fails++;
        end
        tests++;
        if (chain !== 21'b101001010011110011111) begin
            $display("FAIL basic_chain: got %b expected 101001010011110011111", chain);
            fails++;
        end
        @(negedge prog_clk);
        tests++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL basic_done_pulse: got done,busy=%b expected 00", {done, busy});
            fails++;
        end
    endtask

    task automatic test_readback();
        int rbb, dc, gb, ss, sbad;
        rbb = rb_n;
        run_load(8'h12, 8'h34, 8'h56, 0, 0, 1'b0, 0, 8'h00, dc, gb, ss, sbad);
        tests++; if (dc !== 26) begin $display("FAIL readback_done_cycle: got %0d expected 26", dc); fails++; end
        tests++;
        if ({rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]} !== 24'hA53CF8) begin
            $display("FAIL readback_words: got %h %h %h expected a5 3c f8",
                     rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]);
            fails++;
        end
        tests++;
        if (chain !== {8'h12, 8'h34, 5'b01010}) begin
            $display("FAIL readback_chain: got %b expected %b", chain, {8'h12, 8'h34, 5'b01010});
            fails++;
        end
    endtask

    task automatic test_cfg_stall();
        int sb, rbb, dc, gb, ss, sbad;
        sb = shift_cnt; rbb = rb_n;
        run_load(8'hA5, 8'h3C, 8'hF8, 5, 0, 1'b0, 0, 8'h00, dc, gb, ss, sbad);
        tests++; if (dc !== 31) begin $display("FAIL cfgstall_done_cycle: got %0d expected 31", dc); fails++; end
        tests++; if (gb !== 0) begin $display("FAIL cfgstall_no_shift: got %0d shifting gap cycles expected 0", gb); fails++; end
        tests++; if (shift_cnt - sb !== 21) begin $display("FAIL cfgstall_shifts: got %0d expected 21", shift_cnt - sb); fails++; end
        tests++;
        if ({rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]} !== 24'h123450) begin
            $display("FAIL cfgstall_rb_words: got %h %h %h expected 12 34 50",
                     rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]);
            fails++;
        end
        tests++;
        if (chain !== 21'b101001010011110011111) begin
            $display("FAIL cfgstall_chain: got %b expected 101001010011110011111", chain);
            fails++;
        end
    endtask

    task automatic test_rb_stall();
        int sb, rbb, dc, gb, ss, sbad;
        sb = shift_cnt; rbb = rb_n;
        run_load(8'h0F, 8'hF0, 8'h81, 0, 4, 1'b0, 0, 8'hA5, dc, gb, ss, sbad);
        tests++; if (dc !== 30) begin $display("FAIL rbstall_done_cycle: got %0d expected 30", dc); fails++; end
        tests++; if (ss !== 4) begin $display("FAIL rbstall_cycles: got %0d expected 4", ss); fails++; end
        tests++; if (sbad !== 0) begin $display("FAIL rbstall_rb_stable: got %0d unstable cycles expected 0", sbad); fails++; end
        tests++; if (shift_cnt - sb !== 21) begin $display("FAIL rbstall_shifts: got %0d expected 21", shift_cnt - sb); fails++; end
        tests++;
        if ((rb_n - rbb !== 3) ||
            ({rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]} !== 24'hA53CF8)) begin
            $display("FAIL rbstall_rb_words: got %0d words %h %h %h expected 3 words a5 3c f8", rb_n - rbb,
                     rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]);
            fails++;
        end
        tests++;
        if (chain !== {8'h0F, 8'hF0, 5'b10000}) begin
            $display("FAIL rbstall_chain: got %b expected %b", chain, {8'h0F, 8'hF0, 5'b10000});
            fails++;
        end
    endtask

    task automatic test_start_busy();
        int hb, rbb, dc, gb, ss, sbad, bad;
        hb = hs_cnt; bad = 0;
        @(negedge prog_clk);
        cfg_valid = 1'b1; cfg_data = 8'h99; start = 1'b0;
        repeat (3) begin
            @(negedge prog_clk);
            if (cfg_ready !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin $display("FAIL idle_cfg_ready: got %0d cycles ready expected 0", bad); fails++; end
        tests++; if (hs_cnt - hb !== 0) begin $display("FAIL idle_no_accept: got %0d words expected 0", hs_cnt - hb); fails++; end
        hb = hs_cnt; rbb = rb_n;
        run_load(8'h5A, 8'hC3, 8'h7E, 0, 0, 1'b1, 5, 8'h00, dc, gb, ss, sbad);
        tests++; if (dc !== 26) begin $display("FAIL startbusy_done_cycle: got %0d expected 26", dc); fails++; end
        repeat (4) @(negedge prog_clk);
        tests++; if (hs_cnt - hb !== 3) begin $display("FAIL startbusy_words: got %0d expected 3", hs_cnt - hb); fails++; end
        tests++; if (busy !== 1'b0) begin $display("FAIL startbusy_idle: got busy=%b expected 0", busy); fails++; end
        tests++;
        if ({rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]} !== 24'h0FF080) begin
            $display("FAIL startbusy_rb_words: got %h %h %h expected 0f f0 80",
                     rb_words[6'(rbb)], rb_words[6'(rbb+1)], rb_words[6'(rbb+2)]);
            fails++;
        end
        tests++;
        if (chain !== {8'h5A, 8'hC3, 5'b01111}) begin
            $display("FAIL startbusy_chain: got %b expected %b", chain, {8'h5A, 8'hC3, 5'b01111});
            fails++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_abort();
        int sb, hb, rel;
        bit hit;
        logic [CHAIN_LEN-1:0] prev;
        logic [7:0] w1;
        prev = chain; sb = shift_cnt; hb = hs_cnt; hit = 1'b0; w1 = 8'h22;
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b0; rb_ready = 1'b0;
        @(posedge prog_clk);
        for (int n = 0; n < 100; n++) begin
            @(negedge prog_clk);
            start = 1'b0;
            rel = hs_cnt - hb;
            cfg_data  = (rel == 0) ? 8'h11 : w1;
            cfg_valid = (rel < 2);
            #1;
            if (shift_cnt - sb == 10) begin
                hit = 1'b1;
                break;
            end
            @(posedge prog_clk);
        end
        tests++; if (hit !== 1'b1) begin $display("FAIL abort_reach_10: got %0d shifts expected 10", shift_cnt - sb); fails++; end
        tests++; if (rb_valid !== 1'b1) begin $display("FAIL abort_rb_held: got rb_valid=%b expected 1", rb_valid); fails++; end
        prog_reset = 1'b1;
        #1;
        tests++; if (ccff_shift_en !== 1'b0) begin $display("FAIL abort_shift_gated: got %b expected 0", ccff_shift_en); fails++; end
        @(posedge prog_clk);
        @(negedge prog_clk);
        tests++;
        if ({busy, rb_valid, cfg_ready, done} !== 4'b0000) begin
            $display("FAIL abort_idle: got busy,rb_valid,cfg_ready,done=%b expected 0000", {busy, rb_valid, cfg_ready, done});
            fails++;
        end
        prog_reset = 1'b0; cfg_valid = 1'b0; rb_ready = 1'b1;
        repeat (3) @(negedge prog_clk);
        tests++; if (shift_cnt - sb !== 10) begin $display("FAIL abort_shifts: got %0d expected 10", shift_cnt - sb); fails++; end
        tests++;
        if (chain !== {prev[10:0], 8'h11, w1[7:6]}) begin
            $display("FAIL abort_chain: got %b expected %b", chain, {prev[10:0], 8'h11, w1[7:6]});
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_readback();
        test_cfg_stall();
        test_rb_stall();
        test_start_busy();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
